game_layer_mixer: RTL and testbench

// N-layer pixel mixer between sprite/background generators and the VGA output

---
 rtl/game_layer_mixer_if.sv | 30 +++
 rtl/game_layer_mixer.sv | 136 +++++++++++++
 tb/tb_game_layer_mixer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/game_layer_mixer_if.sv
// Pixel-stream bundle between the layer generators and the game_layer_mixer.
// The master side drives pixel/game state and the slave side returns the mixed pixel and collision report.
interface game_layer_mixer_if #(
  parameter int N_LAYERS = 4,
  parameter int RGB_W    = 3
);
  logic                      display_on;
  logic                      frame_start;
  logic [N_LAYERS-1:0]       layer_rgb_en;
  logic [N_LAYERS*RGB_W-1:0] layer_rgb;
  logic [RGB_W-1:0]          background_rgb;
  logic                      game_won;
  logic                      end_of_game_timer_running;
  logic                      random;
  logic [RGB_W-1:0]          rgb;
  logic [N_LAYERS-1:0]       collision_mask;
  logic                      collision_valid;

  modport master (
    output display_on, frame_start, layer_rgb_en, layer_rgb, background_rgb,
           game_won, end_of_game_timer_running, random,
    input  rgb, collision_mask, collision_valid
  );

  modport slave (
    input  display_on, frame_start, layer_rgb_en, layer_rgb, background_rgb,
           game_won, end_of_game_timer_running, random,
    output rgb, collision_mask, collision_valid
  );
endinterface

// File: rtl/game_layer_mixer.sv
// Priority layer mixer with a frame-paced end-of-game flash and per-frame layer
// overlap (collision) reporting, published on each frame_start pulse.
module game_layer_mixer #(
  parameter int N_LAYERS     = 4,
  parameter int RGB_W        = 3,
  parameter int FLASH_FRAMES = 8
) (
  input  logic              clk,
  input  logic              reset,
  game_layer_mixer_if.slave bus
);

  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [N_LAYERS-1:0] LAYER_ONE = N_LAYERS'(1);

  typedef enum logic {
    FLASH_DARK = 1'b0,
    FLASH_LIT  = 1'b1
  } flash_t;

  // Isolates the lowest set bit, i.e. the highest-priority enabled layer.
  function automatic logic [N_LAYERS-1:0] lowest_onehot(input logic [N_LAYERS-1:0] v);
    lowest_onehot = v & (~v + LAYER_ONE);
  endfunction

  flash_t              flash_state_r;
  flash_t              flash_state_s;
  logic [CNT_W-1:0]    frame_cnt_r;
  logic [CNT_W-1:0]    frame_cnt_s;
  logic [N_LAYERS-1:0] sel_s;
  logic [RGB_W-1:0]    layer_pix_s;
  logic [RGB_W-1:0]    flash_pix_s;
  logic [RGB_W-1:0]    rgb_s;
  logic [N_LAYERS-1:0] hit_s;
  logic [N_LAYERS-1:0] hit_acc_r;
  logic [RGB_W-1:0]    rgb_r;
  logic [N_LAYERS-1:0] collision_mask_r;
  logic                collision_valid_r;

  // Flash phase register and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_state_r <= FLASH_LIT;
      frame_cnt_r   <= '0;
    end else begin
      flash_state_r <= flash_state_s;
      frame_cnt_r   <= frame_cnt_s;
    end
  end

  // Flash next state: idle timer keeps the first end-of-game frame lit.
  always_comb begin
    flash_state_s = flash_state_r;
    frame_cnt_s   = frame_cnt_r;
    if (!bus.end_of_game_timer_running) begin
      flash_state_s = FLASH_LIT;
      frame_cnt_s   = '0;
    end else if (bus.frame_start) begin
      if (frame_cnt_r == CNT_LAST) begin
        frame_cnt_s = '0;
        case (flash_state_r)
          FLASH_LIT:  flash_state_s = FLASH_DARK;
          FLASH_DARK: flash_state_s = FLASH_LIT;
          default:    flash_state_s = FLASH_LIT;
        endcase
      end else begin
        frame_cnt_s = frame_cnt_r + CNT_ONE;
      end
    end else begin
      frame_cnt_s = frame_cnt_r;
    end
  end

  // Colour of the highest-priority enabled layer (zero when none enabled).
  always_comb begin
    sel_s       = lowest_onehot(bus.layer_rgb_en);
    layer_pix_s = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      layer_pix_s = layer_pix_s | ({RGB_W{sel_s[i]}} & bus.layer_rgb[i*RGB_W +: RGB_W]);
    end
  end

  // Output pixel priority chain.
  always_comb begin
    flash_pix_s = {1'b1, bus.game_won, {(RGB_W-2){bus.random}}};
    rgb_s       = '0;
    if (!bus.display_on) begin
      rgb_s = '0;
    end else if (bus.end_of_game_timer_running) begin
      if (flash_state_r == FLASH_LIT) begin
        rgb_s = flash_pix_s;
      end else begin
        rgb_s = '0;
      end
    end else if (|bus.layer_rgb_en) begin
      rgb_s = layer_pix_s;
    end else begin
      rgb_s = bus.background_rgb;
    end
  end

  // A layer hits when it is enabled together with any other layer on a visible pixel.
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      hit_s[i] = bus.display_on & bus.layer_rgb_en[i] & (bus.layer_rgb_en != (LAYER_ONE << i));
    end
  end

  // Registered pixel and collision accumulate/publish; frame_start hits seed the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_r             <= '0;
      hit_acc_r         <= '0;
      collision_mask_r  <= '0;
      collision_valid_r <= 1'b0;
    end else begin
      rgb_r <= rgb_s;
      if (bus.frame_start) begin
        collision_mask_r  <= hit_acc_r;
        collision_valid_r <= 1'b1;
        hit_acc_r         <= hit_s;
      end else begin
        collision_valid_r <= 1'b0;
        hit_acc_r         <= hit_acc_r | hit_s;
      end
    end
  end

  assign bus.rgb             = rgb_r;
  assign bus.collision_mask  = collision_mask_r;
  assign bus.collision_valid = collision_valid_r;

endmodule

// File: tb/tb_game_layer_mixer.sv
// Directed bench for game_layer_mixer (N_LAYERS=4, RGB_W=3, FLASH_FRAMES=2).
module tb_game_layer_mixer;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  game_layer_mixer_if #(.N_LAYERS(4), .RGB_W(3)) bus();

  game_layer_mixer #(.N_LAYERS(4), .RGB_W(3), .FLASH_FRAMES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic fs_pulse();
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset = 1'b1;
    bus.display_on = 1'b0;
    bus.frame_start = 1'b0;
    bus.layer_rgb_en = 4'b0000;
    // layer3=111, layer2=011, layer1=010, layer0=100
    bus.layer_rgb = {3'b111, 3'b011, 3'b010, 3'b100};
    bus.background_rgb = 3'b001;
    bus.game_won = 1'b0;
    bus.end_of_game_timer_running = 1'b0;
    bus.random = 1'b0;
    cyc();
    cyc();
    check("reset_rgb", {5'd0, bus.rgb}, 8'h00);
    check("reset_mask", {4'd0, bus.collision_mask}, 8'h00);
    check("reset_valid", {7'd0, bus.collision_valid}, 8'h00);
    reset = 1'b0;

    // Mixing priority
    bus.display_on = 1'b1; bus.layer_rgb_en = 4'b1010; cyc();
    check("mix_1010", {5'd0, bus.rgb}, 8'b010);
    bus.layer_rgb_en = 4'b0000; cyc();
    check("mix_bg", {5'd0, bus.rgb}, 8'b001);
    bus.display_on = 1'b0; bus.layer_rgb_en = 4'b1111; cyc();
    check("mix_blank", {5'd0, bus.rgb}, 8'b000);
    bus.display_on = 1'b1; bus.layer_rgb_en = 4'b0100; cyc();
    check("mix_0100", {5'd0, bus.rgb}, 8'b011);
    bus.layer_rgb_en = 4'b1100; cyc();
    check("mix_1100", {5'd0, bus.rgb}, 8'b011);

    // Publish hits accumulated since reset: 1010 | 1100
    bus.layer_rgb_en = 4'b0000; fs_pulse();
    check("pub0_mask", {4'd0, bus.collision_mask}, 8'b1110);
    check("pub0_valid", {7'd0, bus.collision_valid}, 8'h01);

    // Overlapping frame
    bus.layer_rgb_en = 4'b0011; cyc();
    check("valid_drop", {7'd0, bus.collision_valid}, 8'h00);
    check("mix_0011", {5'd0, bus.rgb}, 8'b100);
    repeat (4) cyc();
    bus.layer_rgb_en = 4'b0000; fs_pulse();
    check("pub1_mask", {4'd0, bus.collision_mask}, 8'b0011);
    check("pub1_valid", {7'd0, bus.collision_valid}, 8'h01);
    cyc();
    check("pub1_valid_1cyc", {7'd0, bus.collision_valid}, 8'h00);
    check("pub1_mask_hold", {4'd0, bus.collision_mask}, 8'b0011);

    // Frame without overlap
    bus.layer_rgb_en = 4'b0001; repeat (3) cyc();
    bus.layer_rgb_en = 4'b0000; fs_pulse();
    check("pub2_mask", {4'd0, bus.collision_mask}, 8'b0000);

    // Hit coincident with frame_start belongs to the new frame
    bus.layer_rgb_en = 4'b0001; cyc();
    bus.layer_rgb_en = 4'b0101; fs_pulse();
    check("pub3_mask", {4'd0, bus.collision_mask}, 8'b0000);
    bus.layer_rgb_en = 4'b0000; repeat (2) cyc();
    fs_pulse();
    check("pub4_mask", {4'd0, bus.collision_mask}, 8'b0101);

    // End-of-game flash, FLASH_FRAMES=2
    bus.layer_rgb_en = 4'b0001; bus.game_won = 1'b1; bus.random = 1'b0;
    bus.end_of_game_timer_running = 1'b1; cyc();
    check("flash_lit0", {5'd0, bus.rgb}, 8'b110);
    bus.random = 1'b1; cyc();
    check("flash_rand", {5'd0, bus.rgb}, 8'b111);
    bus.game_won = 1'b0; cyc();
    check("flash_lost", {5'd0, bus.rgb}, 8'b101);
    bus.game_won = 1'b1; bus.random = 1'b0;
    fs_pulse();
    check("flash_lit_fs1", {5'd0, bus.rgb}, 8'b110);
    cyc();
    check("flash_lit1", {5'd0, bus.rgb}, 8'b110);
    fs_pulse();
    check("flash_lit_fs2", {5'd0, bus.rgb}, 8'b110);
    cyc();
    check("flash_dark0", {5'd0, bus.rgb}, 8'b000);
    fs_pulse();
    check("flash_dark_fs", {5'd0, bus.rgb}, 8'b000);
    cyc();
    check("flash_dark1", {5'd0, bus.rgb}, 8'b000);
    fs_pulse();
    cyc();
    check("flash_relit", {5'd0, bus.rgb}, 8'b110);
    bus.display_on = 1'b0; cyc();
    check("flash_blank", {5'd0, bus.rgb}, 8'b000);
    bus.display_on = 1'b1;
    fs_pulse(); fs_pulse();
    cyc();
    check("flash_dark2", {5'd0, bus.rgb}, 8'b000);
    bus.end_of_game_timer_running = 1'b0; cyc();
    check("timer_drop_mix", {5'd0, bus.rgb}, 8'b100);
    bus.end_of_game_timer_running = 1'b1; cyc();
    check("timer_restart_lit", {5'd0, bus.rgb}, 8'b110);
    bus.end_of_game_timer_running = 1'b0;

    // Reset mid-frame after overlaps
    bus.layer_rgb_en = 4'b1111; repeat (3) cyc();
    fs_pulse();
    check("pre_reset_mask", {4'd0, bus.collision_mask}, 8'b1111);
    cyc();
    reset = 1'b1; bus.frame_start = 1'b1; cyc();
    check("mid_reset_rgb", {5'd0, bus.rgb}, 8'h00);
    check("mid_reset_mask", {4'd0, bus.collision_mask}, 8'h00);
    check("mid_reset_valid", {7'd0, bus.collision_valid}, 8'h00);
    reset = 1'b0; bus.frame_start = 1'b0; bus.layer_rgb_en = 4'b0000; cyc();
    fs_pulse();
    check("post_reset_mask", {4'd0, bus.collision_mask}, 8'h00);
    check("post_reset_valid", {7'd0, bus.collision_valid}, 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
